cpu_bus_bridge: RTL and testbench

- Sits between the 32-bit core's byte memory port (address/in/out/we/ce) and a 16-bit external SRAM/SDRAM controller with a req/ack handshake.
- Holds a single 4-byte read line buffer, so sequential opcode and immediate fetches cost one external fill per 4 bytes.
- Writes are write-through and update the buffer on a hit.
- Stalls the core by deasserting cpu_ce until data is valid or a write has been accepted.

---
 rtl/cpu_bus_bridge.sv | 185 ++++++++++++++++++
 tb/tb_cpu_bus_bridge.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge
//
// Connects the 32-bit core's byte memory port to a 16-bit external memory
// controller that uses a req/ack handshake. A single 4-byte line buffer serves
// sequential reads. Writes go straight through to memory, and they also update
// the buffer when they hit it. The core is held off by cpu_ce=0 until its
// access completes.
//
// Ports
//   clock, reset      system clock; asynchronous active-high reset
//   cpu_address[31:0] byte address from the core (stable while cpu_ce=0)
//   cpu_out[7:0]      write data from the core
//   cpu_we            write request (held while cpu_ce=0)
//   cpu_in[7:0]       read data to the core
//   cpu_ce            1 = the current core access completes this cycle
//   flush             invalidate the line buffer
//   mem_req/mem_we    external request / 1 = write
//   mem_addr          external word address (byte address >> 1)
//   mem_wdata/mem_be  write data (byte replicated) / byte enables
//   mem_rdata/mem_ack read data / one-cycle completion strobe
module cpu_bus_bridge #(
    parameter int          ADDR_W   = 24,
    parameter logic [7:0]  OOR_DATA = 8'hFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       cpu_address,
    input  logic [7:0]        cpu_out,
    input  logic              cpu_we,
    output logic [7:0]        cpu_in,
    output logic              cpu_ce,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_be,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [2:0] {IDLE, FILL0, FILL1, WRITE, WDONE} state_t;

    state_t            state_reg;
    logic              line_valid_reg;
    logic              one_shot_reg;       // fill just finished: serve the waiting read once
    logic              flush_pending_reg;  // flush seen while a fill was in flight
    logic [ADDR_W-3:0] tag_reg;
    logic [31:0]       line_data;

    logic       in_range;
    logic       tag_eq;
    logic       hit;
    logic       ack;
    logic       cpu_ce_next;
    logic [7:0] cpu_in_next;

    assign in_range = (cpu_address[31:ADDR_W] == '0);
    assign tag_eq   = (tag_reg == cpu_address[ADDR_W-1:2]);
    // one_shot_reg lets a flushed fill still deliver its byte, even though
    // line_valid stays 0 after the fill.
    assign hit      = ((line_valid_reg & ~flush) | one_shot_reg) & tag_eq & in_range;
    // An ack that arrives with no request outstanding is ignored.
    assign ack      = mem_ack & mem_req;

    // Line buffer bytes. Each byte has its own register, written by its half
    // of the fill or by a write hit to that byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            localparam state_t FILL_ST = (gi >= 2) ? FILL1 : FILL0;
            logic [7:0] byte_reg;

            always_ff @(posedge clock) begin
                if (ack && state_reg == FILL_ST) begin
                    byte_reg <= mem_rdata[(gi % 2) * 8 +: 8];
                end else if (ack && state_reg == WRITE && line_valid_reg && tag_eq &&
                             cpu_address[1:0] == 2'(gi)) begin
                    byte_reg <= cpu_out;
                end
            end

            assign line_data[gi * 8 +: 8] = byte_reg;
        end
    endgenerate

    // Core-side completion decode. Hits and out-of-range accesses complete
    // with zero wait states.
    always_comb begin
        cpu_ce_next = 1'b0;
        cpu_in_next = 8'h00;
        case (state_reg)
            IDLE: begin
                if (!in_range) begin
                    cpu_ce_next = 1'b1;
                    if (!cpu_we) cpu_in_next = OOR_DATA;
                end else if (!cpu_we && hit) begin
                    cpu_ce_next = 1'b1;
                    cpu_in_next = line_data[{cpu_address[1:0], 3'b000} +: 8];
                end
            end
            WDONE:   cpu_ce_next = 1'b1;
            default: cpu_ce_next = 1'b0;
        endcase
    end

    // Hold both core outputs at 0 while reset is asserted.
    assign cpu_ce = cpu_ce_next & ~reset;
    assign cpu_in = reset ? 8'h00 : cpu_in_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            line_valid_reg    <= 1'b0;
            one_shot_reg      <= 1'b0;
            flush_pending_reg <= 1'b0;
            tag_reg           <= '0;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_addr          <= '0;
            mem_wdata         <= 16'h0000;
            mem_be            <= 2'b00;
        end else begin
            one_shot_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (flush) line_valid_reg <= 1'b0;
                    if (in_range) begin
                        if (cpu_we) begin
                            state_reg <= WRITE;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= cpu_address[ADDR_W-1:1];
                            mem_wdata <= {cpu_out, cpu_out};
                            mem_be    <= cpu_address[0] ? 2'b10 : 2'b01;
                        end else if (!hit) begin
                            // Refilling overwrites the buffer, so the old line
                            // stops being valid right away.
                            state_reg         <= FILL0;
                            line_valid_reg    <= 1'b0;
                            flush_pending_reg <= 1'b0;
                            mem_req           <= 1'b1;
                            mem_we            <= 1'b0;
                            mem_be            <= 2'b11;
                            mem_addr          <= {cpu_address[ADDR_W-1:2], 1'b0};
                        end
                    end
                end
                FILL0: begin
                    if (flush) flush_pending_reg <= 1'b1;
                    if (ack) begin
                        mem_req   <= 1'b0;
                        state_reg <= FILL1;
                    end
                end
                FILL1: begin
                    if (flush) flush_pending_reg <= 1'b1;
                    if (!mem_req) begin
                        // One idle cycle has passed since the first half completed.
                        mem_req  <= 1'b1;
                        mem_addr <= {cpu_address[ADDR_W-1:2], 1'b1};
                    end else if (ack) begin
                        mem_req        <= 1'b0;
                        tag_reg        <= cpu_address[ADDR_W-1:2];
                        line_valid_reg <= ~(flush_pending_reg | flush);
                        one_shot_reg   <= 1'b1;
                        state_reg      <= IDLE;
                    end
                end
                WRITE: begin
                    if (flush) line_valid_reg <= 1'b0;
                    if (ack) begin
                        mem_req   <= 1'b0;
                        state_reg <= WDONE;
                    end
                end
                WDONE: begin
                    if (flush) line_valid_reg <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
module tb_cpu_bus_bridge;

    localparam int ADDR_W = 24;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       cpu_address = 32'h0100_0000;
    logic [7:0]        cpu_out = 8'h00;
    logic              cpu_we = 1'b0;
    logic [7:0]        cpu_in;
    logic              cpu_ce;
    logic              flush = 1'b0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-2:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [1:0]        mem_be;
    logic [15:0]       mem_rdata = 16'h0000;
    logic              mem_ack = 1'b0;

    int total = 0;
    int bad   = 0;

    cpu_bus_bridge #(.ADDR_W(ADDR_W), .OOR_DATA(8'hFF)) dut (
        .clock(clock), .reset(reset),
        .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
        .cpu_in(cpu_in), .cpu_ce(cpu_ce), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    // Memory contents: explicit entries, otherwise a fixed address pattern.
    logic [7:0] ext_mem [int unsigned];
    logic [7:0] ref_mem [int unsigned];

    function automatic logic [7:0] ext_rd(input int unsigned a);
        if (ext_mem.exists(a)) return ext_mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input int unsigned a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // External memory model: acks ack_wait cycles after mem_req is first seen.
    int                ack_wait = 1;
    bit                model_en = 1'b1;
    int                wait_cnt = 0;
    bit                acked = 1'b0;
    logic              prev_req = 1'b0;
    logic [ADDR_W-2:0] prev_maddr = '0;
    logic [ADDR_W-2:0] last_addr = '0;
    logic [15:0]       last_wdata = '0;
    logic [1:0]        last_be = '0;

    always @(negedge clock) begin : model
        int unsigned a;
        if (mem_req && prev_req) check("addr_stable", 32'(mem_addr), 32'(prev_maddr));
        prev_req   = mem_req;
        prev_maddr = mem_addr;
        if (model_en) begin
            mem_ack = 1'b0;
            if (!mem_req) begin
                wait_cnt = 0;
                acked    = 1'b0;
            end else if (!acked) begin
                if (wait_cnt >= ack_wait) begin
                    mem_ack = 1'b1;
                    acked   = 1'b1;
                    a = 32'({mem_addr, 1'b0});
                    if (mem_we) begin
                        if (mem_be[0]) ext_mem[a]     = mem_wdata[7:0];
                        if (mem_be[1]) ext_mem[a + 1] = mem_wdata[15:8];
                        last_addr  = mem_addr;
                        last_wdata = mem_wdata;
                        last_be    = mem_be;
                    end else begin
                        mem_rdata = {ext_rd(a + 1), ext_rd(a)};
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // One core access. fmode: 0 none, 1 flush in first cycle, 2 flush when the
    // second external read request appears. ext counts mem_req rising edges.
    task automatic do_access(input logic [31:0] addr, input logic we, input logic [7:0] wd,
                             input int fmode, output logic [7:0] rd, output int cyc,
                             output int ext);
        bit   done = 1'b0;
        bit   fired = 1'b0;
        logic pr;
        cpu_address = addr;
        cpu_we      = we;
        cpu_out     = wd;
        flush       = (fmode == 1);
        pr  = mem_req;
        cyc = 0;
        ext = 0;
        rd  = 8'h00;
        while (!done && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (mem_req && !pr) ext++;
            pr = mem_req;
            if (cpu_ce) begin
                done = 1'b1;
                rd   = cpu_in;
            end
            if (fmode == 2 && ext == 2 && mem_req && !fired) begin
                flush = 1'b1;
                fired = 1'b1;
            end
            @(posedge clock);
            #1;
            flush = 1'b0;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout addr=%h: no cpu_ce after %0d cycles, required completion", addr, cyc);
        end
    endtask

    typedef struct {
        logic [31:0]       addr;
        logic              we;
        logic [7:0]        wd;
        logic [7:0]        exp_rd;
        int                exp_cyc;
        int                exp_ext;
        logic [ADDR_W-2:0] exp_maddr;
        logic [15:0]       exp_wdata;
        logic [1:0]        exp_be;
    } vec_t;

    vec_t vecs [18];

    initial begin
        logic [7:0]  rd;
        logic [7:0]  exp;
        logic [31:0] addr;
        logic        we;
        logic [7:0]  wd;
        int          cyc;
        int          ext;
        int          n;

        // Test vectors use an ack latency of 2 cycles after the request
        // (model ack_wait=1): read miss = 7 cycles, write = 4 cycles.
        vecs[0]  = '{32'h0000_0000, 1'b0, 8'h00, 8'h11, 7, 2, '0, '0, '0};
        vecs[1]  = '{32'h0000_0001, 1'b0, 8'h00, 8'h22, 1, 0, '0, '0, '0};
        vecs[2]  = '{32'h0000_0002, 1'b0, 8'h00, 8'h33, 1, 0, '0, '0, '0};
        vecs[3]  = '{32'h0000_0003, 1'b0, 8'h00, 8'h44, 1, 0, '0, '0, '0};
        vecs[4]  = '{32'h0000_0001, 1'b1, 8'hAB, 8'h00, 4, 1, 23'h0, 16'hABAB, 2'b10};
        vecs[5]  = '{32'h0000_0001, 1'b0, 8'h00, 8'hAB, 1, 0, '0, '0, '0};
        vecs[6]  = '{32'h0000_0002, 1'b0, 8'h00, 8'h33, 1, 0, '0, '0, '0};
        vecs[7]  = '{32'h0100_0000, 1'b0, 8'h00, 8'hFF, 1, 0, '0, '0, '0};
        vecs[8]  = '{32'h0100_0000, 1'b1, 8'h55, 8'h00, 1, 0, '0, '0, '0};
        vecs[9]  = '{32'hFFFF_FFFF, 1'b0, 8'h00, 8'hFF, 1, 0, '0, '0, '0};
        vecs[10] = '{32'h00FF_FFFF, 1'b0, 8'h00, 8'h9C, 7, 2, '0, '0, '0};
        vecs[11] = '{32'h00FF_FFFC, 1'b0, 8'h00, 8'h99, 1, 0, '0, '0, '0};
        vecs[12] = '{32'h0000_0005, 1'b1, 8'h77, 8'h00, 4, 1, 23'h2, 16'h7777, 2'b10};
        vecs[13] = '{32'h0000_0005, 1'b0, 8'h00, 8'h77, 7, 2, '0, '0, '0};
        vecs[14] = '{32'h0000_0000, 1'b0, 8'h00, 8'h11, 7, 2, '0, '0, '0};
        vecs[15] = '{32'h0000_0001, 1'b0, 8'h00, 8'hAB, 1, 0, '0, '0, '0};
        vecs[16] = '{32'h0000_0000, 1'b1, 8'hCD, 8'h00, 4, 1, 23'h0, 16'hCDCD, 2'b01};
        vecs[17] = '{32'h0000_0000, 1'b0, 8'h00, 8'hCD, 1, 0, '0, '0, '0};

        ext_mem[0] = 8'h11; ext_mem[1] = 8'h22; ext_mem[2] = 8'h33; ext_mem[3] = 8'h44;
        ext_mem[32'h00FF_FFFC] = 8'h99; ext_mem[32'h00FF_FFFD] = 8'h9A;
        ext_mem[32'h00FF_FFFE] = 8'h9B; ext_mem[32'h00FF_FFFF] = 8'h9C;
        ref_mem = ext_mem;

        // Reset state (core parked on an out-of-range read).
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_cpu_in", 32'(cpu_in), 32'd0);
        check("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Directed table.
        ack_wait = 1;
        for (int i = 0; i < 18; i++) begin
            do_access(vecs[i].addr, vecs[i].we, vecs[i].wd, 0, rd, cyc, ext);
            $display("vec %0d addr=%h we=%0b wd=%h rd=%h cycles=%0d ext=%0d",
                     i, vecs[i].addr, vecs[i].we, vecs[i].wd, rd, cyc, ext);
            if (vecs[i].we) begin
                if (vecs[i].addr < 32'h0100_0000) ref_mem[vecs[i].addr] = vecs[i].wd;
            end else begin
                check($sformatf("v%0d_data", i), 32'(rd), 32'(vecs[i].exp_rd));
            end
            check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            check($sformatf("v%0d_ext", i), 32'(ext), 32'(vecs[i].exp_ext));
            if (vecs[i].we && vecs[i].exp_ext == 1) begin
                check($sformatf("v%0d_maddr", i), 32'(last_addr), 32'(vecs[i].exp_maddr));
                check($sformatf("v%0d_wdata", i), 32'(last_wdata), 32'(vecs[i].exp_wdata));
                check($sformatf("v%0d_be", i), 32'(last_be), 32'(vecs[i].exp_be));
            end
        end

        // Flush in IDLE together with a read of a cached byte: treated as a miss.
        do_access(32'h0, 1'b0, 8'h00, 1, rd, cyc, ext);
        $display("flush_idle addr=0 rd=%h cycles=%0d ext=%0d", rd, cyc, ext);
        check("flush_idle_data", 32'(rd), 32'h0000_00CD);
        check("flush_idle_cycles", 32'(cyc), 32'd7);
        check("flush_idle_ext", 32'(ext), 32'd2);

        // Flush during FILL1: data still delivered once, line left invalid.
        do_access(32'h8, 1'b0, 8'h00, 2, rd, cyc, ext);
        $display("flush_fill addr=8 rd=%h cycles=%0d ext=%0d", rd, cyc, ext);
        check("flush_fill_data", 32'(rd), 32'(ref_rd(8)));
        check("flush_fill_ext", 32'(ext), 32'd2);
        do_access(32'h9, 1'b0, 8'h00, 0, rd, cyc, ext);
        $display("after_flush addr=9 rd=%h cycles=%0d ext=%0d", rd, cyc, ext);
        check("after_flush_data", 32'(rd), 32'(ref_rd(9)));
        check("after_flush_ext", 32'(ext), 32'd2);
        do_access(32'hA, 1'b0, 8'h00, 0, rd, cyc, ext);
        $display("refilled addr=a rd=%h cycles=%0d ext=%0d", rd, cyc, ext);
        check("refilled_data", 32'(rd), 32'(ref_rd(10)));
        check("refilled_cycles", 32'(cyc), 32'd1);

        // Reset while FILL0 has a request outstanding, then a late ack.
        model_en    = 1'b0;
        mem_ack     = 1'b0;
        cpu_address = 32'h10;
        cpu_we      = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!mem_req && n < 10);
        check("abort_req_seen", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_rst_req", 32'(mem_req), 32'd0);
        check("abort_rst_ce", 32'(cpu_ce), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset       = 1'b0;
        cpu_address = 32'h0100_0000;
        mem_rdata   = 16'hDEAD;
        mem_ack     = 1'b1;
        @(posedge clock);
        #1;
        check("late_ack_req", 32'(mem_req), 32'd0);
        check("late_ack_ce_oor", 32'(cpu_ce), 32'd1);
        @(negedge clock);
        mem_ack  = 1'b0;
        model_en = 1'b1;
        @(posedge clock);
        #1;
        do_access(32'h10, 1'b0, 8'h00, 0, rd, cyc, ext);
        $display("post_abort addr=10 rd=%h cycles=%0d ext=%0d", rd, cyc, ext);
        check("post_abort_data", 32'(rd), 32'(ref_rd(32'h10)));
        check("post_abort_ext", 32'(ext), 32'd2);

        // Reset in IDLE invalidates a cached line.
        cpu_address = 32'h0100_0000;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        do_access(32'h11, 1'b0, 8'h00, 0, rd, cyc, ext);
        $display("post_reset addr=11 rd=%h cycles=%0d ext=%0d", rd, cyc, ext);
        check("post_reset_data", 32'(rd), 32'(ref_rd(32'h11)));
        check("post_reset_cycles", 32'(cyc), 32'd7);

        // Random stream with random ack latency against the byte scoreboard.
        for (int i = 0; i < 200; i++) begin
            ack_wait = $urandom_range(0, 7);
            n = $urandom_range(0, 9);
            if (n <= 6)      addr = 32'($urandom_range(0, 31));
            else if (n <= 8) addr = 32'h00FF_FFF8 + 32'($urandom_range(0, 7));
            else             addr = ($urandom_range(0, 1) == 0) ? 32'h0100_0000 + 32'($urandom_range(0, 3))
                                                                : 32'hFFFF_FFFC;
            we = ($urandom_range(0, 2) == 0);
            wd = 8'($urandom_range(0, 255));
            exp = (addr < 32'h0100_0000) ? ref_rd(addr) : 8'hFF;
            do_access(addr, we, wd, 0, rd, cyc, ext);
            $display("rnd %0d addr=%h we=%0b wd=%h rd=%h lat=%0d cycles=%0d", i, addr, we, wd, rd, ack_wait, cyc);
            if (we) begin
                if (addr < 32'h0100_0000) ref_mem[addr] = wd;
            end else begin
                check($sformatf("rnd%0d_data", i), 32'(rd), 32'(exp));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
